// File: rtl/btn_led_pkg.sv
// Shared types and defaults for the push-button LED mode controller.
package btn_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10
    } mode_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF   = 120000;
    localparam int unsigned BLINK_HALF_PERIOD_DEF = 6000000;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_led_mode_ctrl_if.sv
// Board-side signals: raw buttons in, LEDs out.
interface btn_led_mode_ctrl_if;

    logic [1:0] btn;
    logic [1:0] led;

    modport master (output btn, input led);
    modport slave  (input btn, output led);

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-level debouncer and press pulse for one button.
module btn_debounce
    import btn_led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);

    logic          meta_q, sync_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = stable_q & ~stable_dly_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q       <= 1'b0;
            sync_q       <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            meta_q       <= btn_i;
            sync_q       <= meta_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/btn_led_mode_ctrl.sv
// Debounced STEP/CLEAR buttons drive an OFF/ON/BLINK LED mode machine.
module btn_led_mode_ctrl
    import btn_led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned BLINK_HALF_PERIOD = BLINK_HALF_PERIOD_DEF
) (
    input logic                sysclk,
    input logic                rst_n,
    btn_led_mode_ctrl_if.slave bus
);

    localparam int unsigned BW = cnt_w(BLINK_HALF_PERIOD);

    logic          press_step, press_clr;
    mode_t         mode_q, mode_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk     (sysclk),
        .rst_n   (rst_n),
        .btn_i   (bus.btn[0]),
        .press_o (press_step)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk     (sysclk),
        .rst_n   (rst_n),
        .btn_i   (bus.btn[1]),
        .press_o (press_clr)
    );

    always_comb begin
        mode_d = MODE_OFF;
        case (mode_q)
            MODE_OFF:   mode_d = press_step ? MODE_ON    : MODE_OFF;
            MODE_ON:    mode_d = press_step ? MODE_BLINK : MODE_ON;
            MODE_BLINK: mode_d = press_step ? MODE_OFF   : MODE_BLINK;
            default:    mode_d = MODE_OFF;
        endcase
        if (press_clr) begin
            mode_d = MODE_OFF;
        end
    end

    // Blink restarts lit on every entry so each BLINK visit looks the same.
    always_comb begin
        bcnt_d  = '0;
        phase_d = 1'b0;
        if (mode_d == MODE_BLINK) begin
            if (mode_q != MODE_BLINK) begin
                phase_d = 1'b1;
            end else if (bcnt_q == BW'(BLINK_HALF_PERIOD - 1)) begin
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign bus.led[0] = (mode_q == MODE_ON) |
                        ((mode_q == MODE_BLINK) & phase_q);
    assign bus.led[1] = (mode_q != MODE_OFF);

endmodule

// File: tb/tb_btn_led_mode_ctrl.sv
// Scoreboard bench: stimulus queues expected LED values per cycle, a monitor checks them.
module tb_btn_led_mode_ctrl;

    typedef struct {
        int         cyc;
        logic [1:0] led;
        string      nm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];

    btn_led_mode_ctrl_if bus ();

    btn_led_mode_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .BLINK_HALF_PERIOD (8)
    ) dut (
        .sysclk (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compare every queued expectation whose cycle has come.
    initial begin
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc <= cyc) begin
                    checks++;
                    if (q[i].cyc < cyc) begin
                        errors++;
                        $display("FAIL %s: check for cycle %0d missed (now %0d)",
                                 q[i].nm, q[i].cyc, cyc);
                    end else if (bus.led !== q[i].led) begin
                        errors++;
                        $display("FAIL %s: cycle %0d led=%b expected %b",
                                 q[i].nm, cyc, bus.led, q[i].led);
                    end
                    q.delete(i);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp(input int from, input int n, input logic [1:0] v,
                       input string nm);
        for (int i = 0; i < n; i++) begin
            q.push_back('{from + i, v, nm});
        end
    endtask

    // BLINK with half-period 8: lit for 8 cycles, dark for 8, starting lit.
    task automatic exp_blink(input int from, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            q.push_back('{from + i, ((i / 8) % 2 == 0) ? 2'b11 : 2'b10, nm});
        end
    endtask

    task automatic press(input logic [1:0] m, input int hold, input int low);
        bus.btn = m;
        tick(hold);
        bus.btn = 2'b00;
        tick(low);
    endtask

    int c;
    logic [1:0] bounce [5];
    logic [1:0] finalm [2];

    initial begin
        rst_n   = 1'b0;
        bus.btn = 2'b00;
        tick(3);

        c = cyc;
        exp(c, 1, 2'b00, "reset");
        rst_n = 1'b1;
        exp(c + 1, 20, 2'b00, "idle");
        tick(20);

        // Held STEP: one press, mode ON at the 8th edge, no auto-repeat.
        c = cyc;
        exp(c, 8, 2'b00, "step_latency");
        exp(c + 8, 23, 2'b11, "step_held");
        bus.btn = 2'b01;
        tick(20);
        bus.btn = 2'b00;
        tick(10);

        c = cyc;
        exp(c, 8, 2'b11, "clr_latency");
        exp(c + 8, 12, 2'b00, "clr");
        press(2'b10, 10, 10);

        c = cyc;
        exp(c, 25, 2'b00, "bounce");
        bounce = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            bus.btn = bounce[i];
            tick(1);
        end
        bus.btn = 2'b00;
        tick(20);

        // Full OFF -> ON -> BLINK -> OFF cycle with a long BLINK stay.
        c = cyc;
        exp(c, 8, 2'b00, "seq_off");
        exp(c + 8, 20, 2'b11, "seq_on");
        exp_blink(c + 28, 40, "seq_blink");
        exp(c + 68, 12, 2'b00, "seq_off2");
        press(2'b01, 10, 10);
        press(2'b01, 10, 30);
        press(2'b01, 10, 10);

        // Leave BLINK via simultaneous STEP+CLEAR, then via CLEAR alone.
        finalm = '{2'b11, 2'b10};
        for (int k = 0; k < 2; k++) begin
            c = cyc;
            exp(c, 8, 2'b00, "clrblk_off");
            exp(c + 8, 20, 2'b11, "clrblk_on");
            exp_blink(c + 28, 20, "clrblk_blink");
            exp(c + 48, 12, 2'b00, "clrblk_cleared");
            press(2'b01, 10, 10);
            press(2'b01, 10, 10);
            press(finalm[k], 10, 10);
        end

        // Reset pulse while STEP is held.
        c = cyc;
        exp(c, 8, 2'b00, "rst_pre");
        exp(c + 8, 4, 2'b11, "rst_on");
        exp(c + 12, 11, 2'b00, "rst_async");
        exp(c + 23, 8, 2'b11, "rst_repress");
        bus.btn = 2'b01;
        tick(12);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(16);
        bus.btn = 2'b00;
        tick(10);

        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            tick(1);
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
